ps2_key_tx: RTL and testbench

Keyboard-side PS/2 transmitter. It is the inverse of the scan-code-to-hex decoder: it takes one hex digit, or an Enter request, and emits the full key-press sequence on the PS/2 lines. The sequence is make code, then F0, then the code again. The block serves as a keyboard emulator for bench and board loopback tests of the receive path.

---
 rtl/ps2_pkg.sv | 68 ++++++
 rtl/ps2_frame_tx.sv | 101 ++++++++++
 rtl/ps2_key_tx.sv | 159 +++++++++++++++
 tb/tb_ps2_key_tx.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_pkg
//  Purpose  : Shared scan-code constants, frame length, sequencer state
//             enum and digit-to-scan-code lookup for the PS/2 key emulator.
//  Revision : 1.0  initial release
// ============================================================================
package ps2_pkg;

   localparam int FRAME_BITS = 11;

   localparam logic [7:0] ENTER_CODE = 8'h5A;
   localparam logic [7:0] BREAK_CODE = 8'hF0;

   // Set-2 make codes for the hex digits 0..F
   localparam logic [7:0] SC_0 = 8'h45;
   localparam logic [7:0] SC_1 = 8'h16;
   localparam logic [7:0] SC_2 = 8'h1E;
   localparam logic [7:0] SC_3 = 8'h26;
   localparam logic [7:0] SC_4 = 8'h25;
   localparam logic [7:0] SC_5 = 8'h2E;
   localparam logic [7:0] SC_6 = 8'h36;
   localparam logic [7:0] SC_7 = 8'h3D;
   localparam logic [7:0] SC_8 = 8'h3E;
   localparam logic [7:0] SC_9 = 8'h46;
   localparam logic [7:0] SC_A = 8'h1C;
   localparam logic [7:0] SC_B = 8'h32;
   localparam logic [7:0] SC_C = 8'h21;
   localparam logic [7:0] SC_D = 8'h23;
   localparam logic [7:0] SC_E = 8'h24;
   localparam logic [7:0] SC_F = 8'h2B;

   // Key-press sequencer: make code, gap, break prefix, gap, code, gap
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_MAKE = 3'd1,
      ST_GAP1 = 3'd2,
      ST_BRK  = 3'd3,
      ST_GAP2 = 3'd4,
      ST_CODE = 3'd5,
      ST_GAP3 = 3'd6
   } seq_state_t;

   function automatic logic [7:0] digit_to_scancode(input logic [3:0] digit);
      logic [7:0] code;
      case (digit)
         4'h0:    code = SC_0;
         4'h1:    code = SC_1;
         4'h2:    code = SC_2;
         4'h3:    code = SC_3;
         4'h4:    code = SC_4;
         4'h5:    code = SC_5;
         4'h6:    code = SC_6;
         4'h7:    code = SC_7;
         4'h8:    code = SC_8;
         4'h9:    code = SC_9;
         4'hA:    code = SC_A;
         4'hB:    code = SC_B;
         4'hC:    code = SC_C;
         4'hD:    code = SC_D;
         4'hE:    code = SC_E;
         default: code = SC_F;
      endcase
      return code;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_frame_tx.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_frame_tx
//  Purpose  : Sends one 11-bit PS/2 frame (start, 8 data LSB first, odd
//             parity, stop). Each bit slot is 2*HALF_PERIOD cycles: clock
//             high for the first half, low for the second, data updated on
//             the first cycle of the slot.
//  Revision : 1.0  initial release
// ============================================================================
module ps2_frame_tx
   import ps2_pkg::*;
#(
   parameter int HALF_PERIOD = 2500
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] tx_byte,
   output logic       busy,
   output logic       ps2_clk,
   output logic       ps2_data
);

   localparam int SLOT_CYCLES = 2 * HALF_PERIOD;
   localparam int CNT_W       = $clog2(SLOT_CYCLES);
   localparam int BIT_W       = $clog2(FRAME_BITS);

   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_PERIOD - 1);
   localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_CYCLES - 1);
   localparam logic [BIT_W-1:0] STOP_IDX  = BIT_W'(FRAME_BITS - 1);

   logic [CNT_W-1:0]      half_cnt_q, half_cnt_d;
   logic [BIT_W-1:0]      bit_idx_q,  bit_idx_d;
   logic [FRAME_BITS-1:0] shift_q,    shift_d;
   logic                  busy_q,     busy_d;
   logic                  ps2_clk_q,  ps2_clk_d;
   logic                  ps2_data_q, ps2_data_d;

   // Slot timing: load frame on start, drop clock mid-slot, advance bit at slot end
   always_comb begin
      half_cnt_d = half_cnt_q;
      bit_idx_d  = bit_idx_q;
      shift_d    = shift_q;
      busy_d     = busy_q;
      ps2_clk_d  = ps2_clk_q;
      ps2_data_d = ps2_data_q;
      if (start) begin
         busy_d     = 1'b1;
         half_cnt_d = '0;
         bit_idx_d  = '0;
         shift_d    = {1'b1, ~^tx_byte, tx_byte, 1'b0};
         ps2_clk_d  = 1'b1;
         ps2_data_d = 1'b0;
      end else if (busy_q) begin
         if (half_cnt_q == SLOT_LAST) begin
            half_cnt_d = '0;
            ps2_clk_d  = 1'b1;
            if (bit_idx_q == STOP_IDX) begin
               // stop bit already drives data high; lines stay idle
               busy_d     = 1'b0;
               bit_idx_d  = '0;
               ps2_data_d = 1'b1;
            end else begin
               bit_idx_d  = bit_idx_q + 1'b1;
               shift_d    = {1'b1, shift_q[FRAME_BITS-1:1]};
               ps2_data_d = shift_q[1];
            end
         end else begin
            half_cnt_d = half_cnt_q + 1'b1;
            if (half_cnt_q == HALF_LAST) begin
               ps2_clk_d = 1'b0;
            end
         end
      end
   end

   // State and line registers; reset forces both lines high immediately
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         half_cnt_q <= '0;
         bit_idx_q  <= '0;
         shift_q    <= '1;
         busy_q     <= 1'b0;
         ps2_clk_q  <= 1'b1;
         ps2_data_q <= 1'b1;
      end else begin
         half_cnt_q <= half_cnt_d;
         bit_idx_q  <= bit_idx_d;
         shift_q    <= shift_d;
         busy_q     <= busy_d;
         ps2_clk_q  <= ps2_clk_d;
         ps2_data_q <= ps2_data_d;
      end
   end

   assign busy     = busy_q;
   assign ps2_clk  = ps2_clk_q;
   assign ps2_data = ps2_data_q;

endmodule
`default_nettype wire

// File: rtl/ps2_key_tx.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_key_tx
//  Purpose  : Keyboard-side PS/2 key emulator. Accepts a hex digit or Enter
//             and emits make code, F0, code, each frame followed by an idle
//             gap of GAP_CYCLES cycles, then pulses done.
//  Revision : 1.0  initial release
// ============================================================================
module ps2_key_tx
   import ps2_pkg::*;
#(
   parameter int HALF_PERIOD = 2500,
   parameter int GAP_CYCLES  = 50000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [3:0] req_digit,
   input  logic       req_enter,
   output logic       done,
   output logic       ps2_clk,
   output logic       ps2_data
);

   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
   localparam logic [GAP_W-1:0] GAP_FIRST = GAP_W'(1);
   // The first idle cycle after a frame is spent in the frame state itself
   // (where busy has just dropped), so a one-cycle gap never enters GAPn.
   localparam logic GAP_ONE = (GAP_CYCLES == 1);

   seq_state_t       state_q,   state_d;
   logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
   logic [7:0]       code_q,    code_d;
   logic             done_q,    done_d;

   logic             frm_start;
   logic [7:0]       frm_byte;
   logic             frm_busy;

   // Sequencer: handshake, frame launches and gap timing
   always_comb begin
      state_d   = state_q;
      gap_cnt_d = gap_cnt_q;
      code_d    = code_q;
      done_d    = 1'b0;
      frm_start = 1'b0;
      frm_byte  = code_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               code_d    = req_enter ? ENTER_CODE : digit_to_scancode(req_digit);
               frm_byte  = code_d;
               frm_start = 1'b1;
               state_d   = ST_MAKE;
            end
         end
         ST_MAKE: begin
            if (!frm_busy) begin
               if (GAP_ONE) begin
                  frm_start = 1'b1;
                  frm_byte  = BREAK_CODE;
                  state_d   = ST_BRK;
               end else begin
                  gap_cnt_d = GAP_FIRST;
                  state_d   = ST_GAP1;
               end
            end
         end
         ST_GAP1: begin
            if (gap_cnt_q == GAP_LAST) begin
               gap_cnt_d = '0;
               frm_start = 1'b1;
               frm_byte  = BREAK_CODE;
               state_d   = ST_BRK;
            end else begin
               gap_cnt_d = gap_cnt_q + 1'b1;
            end
         end
         ST_BRK: begin
            if (!frm_busy) begin
               if (GAP_ONE) begin
                  frm_start = 1'b1;
                  state_d   = ST_CODE;
               end else begin
                  gap_cnt_d = GAP_FIRST;
                  state_d   = ST_GAP2;
               end
            end
         end
         ST_GAP2: begin
            if (gap_cnt_q == GAP_LAST) begin
               gap_cnt_d = '0;
               frm_start = 1'b1;
               state_d   = ST_CODE;
            end else begin
               gap_cnt_d = gap_cnt_q + 1'b1;
            end
         end
         ST_CODE: begin
            if (!frm_busy) begin
               if (GAP_ONE) begin
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  gap_cnt_d = GAP_FIRST;
                  state_d   = ST_GAP3;
               end
            end
         end
         ST_GAP3: begin
            if (gap_cnt_q == GAP_LAST) begin
               gap_cnt_d = '0;
               done_d    = 1'b1;
               state_d   = ST_IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q + 1'b1;
            end
         end
         default: begin
            gap_cnt_d = '0;
            state_d   = ST_IDLE;
         end
      endcase
   end

   // Sequencer registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         gap_cnt_q <= '0;
         code_q    <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         gap_cnt_q <= gap_cnt_d;
         code_q    <= code_d;
         done_q    <= done_d;
      end
   end

   ps2_frame_tx #(
      .HALF_PERIOD (HALF_PERIOD)
   ) u_frame_tx (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (frm_start),
      .tx_byte  (frm_byte),
      .busy     (frm_busy),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data)
   );

   assign req_ready = (state_q == ST_IDLE);
   assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_ps2_key_tx
//  Purpose  : Self-checking bench for ps2_key_tx with a cycle-level line
//             model derived from the frame/gap timing rules.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ps2_key_tx;

   localparam int HP        = 4;
   localparam int GAP       = 8;
   localparam int FRAME_LEN = 22 * HP;
   localparam int SEQ_LEN   = 66 * HP + 3 * GAP;

   logic       clk       = 1'b0;
   logic       rst_n     = 1'b1;
   logic       req_valid = 1'b0;
   logic       req_enter = 1'b0;
   logic [3:0] req_digit = 4'h0;
   logic       req_ready;
   logic       done;
   logic       ps2_clk;
   logic       ps2_data;

   int total = 0;
   int bad   = 0;

   logic [7:0] ref_map [16] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                8'h3E, 8'h46, 8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B};

   always #5 clk = ~clk;

   ps2_key_tx #(
      .HALF_PERIOD (HP),
      .GAP_CYCLES  (GAP)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_digit (req_digit),
      .req_enter (req_enter),
      .done      (done),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data)
   );

   function automatic logic [7:0] ref_code(input logic [3:0] d, input logic e);
      return e ? 8'h5A : ref_map[d];
   endfunction

   // 11-bit frame, bit 0 sent first
   function automatic logic [10:0] ref_frame(input logic [7:0] code);
      int ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(code[i]);
      return {1'b1, ((ones % 2) == 0) ? 1'b1 : 1'b0, code, 1'b0};
   endfunction

   // Expected lines in cycle k after the accept edge (k = 1 is the first)
   function automatic void ref_lines(input int k, input logic [7:0] code,
                                     output logic eclk, output logic edata);
      int per = FRAME_LEN + GAP;
      int f   = (k - 1) / per;
      int w   = (k - 1) % per;
      logic [10:0] fr;
      eclk  = 1'b1;
      edata = 1'b1;
      if (f < 3 && w < FRAME_LEN) begin
         fr    = ref_frame((f == 1) ? 8'hF0 : code);
         eclk  = ((w % (2 * HP)) < HP);
         edata = fr[w / (2 * HP)];
      end
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Line protocol monitor: data stable while clock low, low phase = HP cycles
   int   proto_bad     = 0;
   int   low_len       = 0;
   logic mon_prev_clk  = 1'b1;
   logic mon_prev_data = 1'b1;
   always @(negedge clk) begin
      if (!rst_n) begin
         low_len       = 0;
         mon_prev_clk  = 1'b1;
         mon_prev_data = 1'b1;
      end else begin
         if (mon_prev_clk === 1'b0 && ps2_clk === 1'b0 && ps2_data !== mon_prev_data)
            proto_bad++;
         if (ps2_clk === 1'b0) begin
            low_len++;
         end else begin
            if (mon_prev_clk === 1'b0 && low_len != HP) proto_bad++;
            low_len = 0;
         end
         mon_prev_clk  = ps2_clk;
         mon_prev_data = ps2_data;
      end
   end

   // Follows one accepted request to its done cycle; returns at that negedge
   task automatic watch_seq(input logic [7:0] code, input bit hold, input string tag);
      logic        eclk, edata;
      logic        prev_clk = 1'b1;
      int          wave_bad = 0, first_bad = -1, n_fall = 0;
      int          done_at = -1, done_cnt = 0, rdy_bad = 0;
      logic [32:0] bits = '0;
      for (int k = 1; k <= SEQ_LEN + 1; k++) begin
         @(negedge clk);
         if (hold && k <= SEQ_LEN) req_digit = 4'($urandom);
         ref_lines(k, code, eclk, edata);
         if (ps2_clk !== eclk || ps2_data !== edata) begin
            wave_bad++;
            if (first_bad < 0) first_bad = k;
         end
         if (prev_clk === 1'b1 && ps2_clk === 1'b0) begin
            if (n_fall < 33) bits[n_fall] = ps2_data;
            n_fall++;
         end
         prev_clk = ps2_clk;
         if (done === 1'b1) begin
            done_cnt++;
            if (done_at < 0) done_at = k;
         end
         if (k <= SEQ_LEN && req_ready !== 1'b0) rdy_bad++;
      end
      check($sformatf("%s wave errors (first at k=%0d)", tag, first_bad), wave_bad, 0);
      check({tag, " falling edges"}, n_fall, 33);
      for (int f = 0; f < 3; f++)
         check($sformatf("%s frame%0d", tag, f), 32'(bits[f*11 +: 11]),
               32'(ref_frame((f == 1) ? 8'hF0 : code)));
      check({tag, " done cycle"}, done_at, SEQ_LEN + 1);
      check({tag, " done pulses"}, done_cnt, 1);
      check({tag, " ready low while busy"}, rdy_bad, 0);
      check({tag, " ready in done cycle"}, 32'(req_ready), 1);
   endtask

   // Present a request at the current negedge, then follow it
   task automatic run_one(input logic [3:0] d, input logic e, input bit hold, input string tag);
      check({tag, " ready before"}, 32'(req_ready), 1);
      req_digit = d;
      req_enter = e;
      req_valid = 1'b1;
      @(posedge clk);
      #1;
      if (!hold) req_valid = 1'b0;
      watch_seq(ref_code(d, e), hold, tag);
      req_valid = 1'b0;
      req_enter = 1'b0;
   endtask

   initial begin : stim
      logic [3:0] d;
      logic       eclk, edata;
      int         junk, dn;

      // Reset
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("reset ready", 32'(req_ready), 1);
      check("reset done", 32'(done), 0);
      check("reset lines", {30'd0, ps2_clk, ps2_data}, 32'h3);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle lines", {30'd0, ps2_clk, ps2_data}, 32'h3);

      // Directed: digit 0, then Enter overriding digit 3
      run_one(4'h0, 1'b0, 1'b0, "digit0");
      run_one(4'h3, 1'b1, 1'b0, "enter3");
      run_one(4'($urandom), 1'b1, 1'b0, "enter_rand");

      // Back-to-back sweep: each request presented in the previous done cycle
      for (int i = 0; i < 16; i++)
         run_one(4'(i), 1'b0, 1'b0, $sformatf("sweep%0h", i));

      // Random requests
      for (int i = 0; i < 4; i++)
         run_one(4'($urandom), ($urandom_range(0, 3) == 0), 1'b0, $sformatf("rand%0d", i));

      // req_valid held with changing digit during the transfer
      run_one(4'($urandom), 1'b0, 1'b1, "hold");
      dn = 0;
      repeat (5) begin
         @(negedge clk);
         if (done === 1'b1) dn++;
      end
      check("hold no extra done", dn, 0);

      // Reset mid-way through the break frame
      d = 4'($urandom);
      req_digit = d;
      req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      repeat (FRAME_LEN + GAP + 31) @(negedge clk);
      ref_lines(FRAME_LEN + GAP + 31, ref_code(d, 1'b0), eclk, edata);
      check("pre-reset lines", {30'd0, ps2_clk, ps2_data}, {30'd0, eclk, edata});
      #1 rst_n = 1'b0;
      #1;
      check("async reset lines", {30'd0, ps2_clk, ps2_data}, 32'h3);
      check("async reset ready", 32'(req_ready), 1);
      check("async reset done", 32'(done), 0);
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;
      dn   = 0;
      junk = 0;
      repeat (SEQ_LEN + 32) begin
         @(negedge clk);
         if (done === 1'b1) dn++;
         if (ps2_clk !== 1'b1 || ps2_data !== 1'b1) junk++;
      end
      check("post-reset done pulses", dn, 0);
      check("post-reset line activity", junk, 0);
      run_one(4'($urandom), 1'b0, 1'b0, "after_reset");

      check("protocol violations", proto_bad, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
